// File: rtl/cache_control_assoc_if.sv
// Bus between the core's memory stage / main memory and the set-associative cache controller.
// Signals:
//   addr, rd_en, wr_en, invalid : CPU request (held stable by the core while stall=1)
//   hit, stall, way_sel          : lookup result and core hold
//   cache_addr, data_we,
//   refill_we                    : data-array word address {set, way, word} and write strobes
//   mem_req, mem_addr, mem_valid : block refill handshake with main memory
//   hit_count, miss_count        : statistics, present only when CACHE_STATS_EN is defined
// Modports: master = core/memory side, slave = cache controller.
interface cache_control_assoc_if #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned SETS            = 4,
  parameter int unsigned WAYS            = 2,
  parameter int unsigned WORDS_PER_BLOCK = 4
);
  localparam int unsigned WayW   = $clog2(WAYS);
  localparam int unsigned CaddrW = $clog2(SETS * WAYS * WORDS_PER_BLOCK);

  logic [ADDR_WIDTH-1:0] addr;
  logic                  rd_en;
  logic                  wr_en;
  logic                  invalid;
  logic                  hit;
  logic                  stall;
  logic [WayW-1:0]       way_sel;
  logic [CaddrW-1:0]     cache_addr;
  logic                  data_we;
  logic                  refill_we;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_valid;
`ifdef CACHE_STATS_EN
  logic [31:0]           hit_count;
  logic [31:0]           miss_count;

  modport master (
    output addr, rd_en, wr_en, invalid, mem_valid,
    input  hit, stall, way_sel, cache_addr, data_we, refill_we, mem_req, mem_addr,
    input  hit_count, miss_count
  );
  modport slave (
    input  addr, rd_en, wr_en, invalid, mem_valid,
    output hit, stall, way_sel, cache_addr, data_we, refill_we, mem_req, mem_addr,
    output hit_count, miss_count
  );
`else
  modport master (
    output addr, rd_en, wr_en, invalid, mem_valid,
    input  hit, stall, way_sel, cache_addr, data_we, refill_we, mem_req, mem_addr
  );
  modport slave (
    input  addr, rd_en, wr_en, invalid, mem_valid,
    output hit, stall, way_sel, cache_addr, data_we, refill_we, mem_req, mem_addr
  );
`endif
endinterface

// File: rtl/cache_control_assoc.sv
// N-way set-associative cache tag/valid controller, write-through, no-write-allocate.
// Holds tags, valid bits and a per-set round-robin victim pointer; detects hits, drives the
// data-array word address and refills a whole block from main memory on a read miss.
// Ports:
//   clk   : clock, all state changes on posedge
//   reset : synchronous active-low reset
//   bus   : cache_control_assoc_if.slave (CPU request, data-array strobes, refill handshake)
// Optional: define CACHE_STATS_EN to add 32-bit hit_count / miss_count outputs on the bus.
module cache_control_assoc #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned SETS            = 4,
  parameter int unsigned WAYS            = 2,
  parameter int unsigned WORDS_PER_BLOCK = 4
) (
  input logic                  clk,
  input logic                  reset,
  cache_control_assoc_if.slave bus
);
  localparam int unsigned WordW = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned SetW  = $clog2(SETS);
  localparam int unsigned WayW  = $clog2(WAYS);
  localparam int unsigned OffW  = WordW + 2;
  localparam int unsigned BlkW  = ADDR_WIDTH - OffW;
  localparam int unsigned TagW  = BlkW - SetW;

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StRefill = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WAYS-1:0]  valid_q [SETS];
  logic [TagW-1:0]  tag_q   [SETS][WAYS];
  logic [WayW-1:0]  rr_q    [SETS];
  logic [WayW-1:0]  victim_q, victim_d;
  logic             use_rr_q, use_rr_d;
  logic [WordW-1:0] beat_q, beat_d;
  logic [BlkW-1:0]  blk_q, blk_d;
  logic             mem_req_q, mem_req_d;

  logic [WordW-1:0] word;
  logic [SetW-1:0]  set_idx;
  logic [TagW-1:0]  tag;
  logic [SetW-1:0]  fill_set;
  logic [TagW-1:0]  fill_tag;
  logic             idle, hit_any, free_any, rd_miss, fill_done, inval_en;
  logic [WayW-1:0]  hit_way, free_way;
  logic             unused_addr;

  assign word        = bus.addr[OffW-1:2];
  assign set_idx     = bus.addr[OffW+SetW-1:OffW];
  assign tag         = bus.addr[ADDR_WIDTH-1:OffW+SetW];
  assign unused_addr = ^bus.addr[1:0];
  assign fill_set    = blk_q[SetW-1:0];
  assign fill_tag    = blk_q[BlkW-1:SetW];

  // Descending scans so the lowest matching / lowest free way wins.
  always_comb begin
    hit_any  = 1'b0;
    hit_way  = '0;
    free_any = 1'b0;
    free_way = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == tag)) begin
        hit_any = 1'b1;
        hit_way = WayW'(w);
      end
      if (!valid_q[set_idx][w]) begin
        free_any = 1'b1;
        free_way = WayW'(w);
      end
    end
  end

  assign idle      = (state_q == StIdle);
  assign rd_miss   = idle && bus.rd_en && !bus.wr_en && !hit_any;
  assign inval_en  = idle && bus.invalid && hit_any;
  assign fill_done = !idle && bus.mem_valid && (beat_q == WordW'(WORDS_PER_BLOCK - 1));

  always_comb begin
    state_d   = state_q;
    victim_d  = victim_q;
    use_rr_d  = use_rr_q;
    beat_d    = beat_q;
    blk_d     = blk_q;
    mem_req_d = mem_req_q;
    if (rd_miss) begin
      state_d   = StRefill;
      victim_d  = free_any ? free_way : rr_q[set_idx];
      use_rr_d  = !free_any;
      beat_d    = '0;
      blk_d     = bus.addr[ADDR_WIDTH-1:OffW];
      mem_req_d = 1'b1;
    end else if (!idle && bus.mem_valid) begin
      beat_d = beat_q + 1'b1;
      if (fill_done) begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      victim_q  <= '0;
      use_rr_q  <= 1'b0;
      beat_q    <= '0;
      blk_q     <= '0;
      mem_req_q <= 1'b0;
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
        for (int w = 0; w < int'(WAYS); w++) tag_q[s][w] <= '0;
      end
    end else begin
      state_q   <= state_d;
      victim_q  <= victim_d;
      use_rr_q  <= use_rr_d;
      beat_q    <= beat_d;
      blk_q     <= blk_d;
      mem_req_q <= mem_req_d;
      if (inval_en) valid_q[set_idx][hit_way] <= 1'b0;
      if (fill_done) begin
        tag_q[fill_set][victim_q]   <= fill_tag;
        valid_q[fill_set][victim_q] <= 1'b1;
        // Pointer only moves when it actually chose the victim.
        if (use_rr_q) rr_q[fill_set] <= rr_q[fill_set] + 1'b1;
      end
    end
  end

  assign bus.hit        = hit_any;
  assign bus.stall      = !idle || rd_miss;
  assign bus.way_sel    = idle ? hit_way : victim_q;
  assign bus.cache_addr = idle ? {set_idx, hit_way, word} : {fill_set, victim_q, beat_q};
  assign bus.data_we    = idle && bus.wr_en && hit_any;
  assign bus.refill_we  = !idle && bus.mem_valid;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = {blk_q, {OffW{1'b0}}};

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        req_any;

  assign req_any = idle && (bus.rd_en || bus.wr_en);

  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (req_any && hit_any)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (req_any && !hit_any) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
`endif
endmodule

// File: tb/tb_cache_control_assoc.sv
// Directed bench for cache_control_assoc (default 4 sets x 2 ways x 4 words, 32-bit addresses).
// Addresses used: set = addr[5:4], word = addr[3:2], tag = addr[31:6].
module tb_cache_control_assoc;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  cache_control_assoc_if bus ();

  cache_control_assoc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read miss on a, full refill with one idle gap cycle, then check the resulting hit.
  // base = data-array address of word 0 of the expected victim line.
  task automatic refill(input logic [31:0] a, input logic [4:0] base);
    bus.addr = a; bus.rd_en = 1'b1; bus.wr_en = 1'b0; bus.invalid = 1'b0;
    bus.mem_valid = 1'b0;
    #1;
    check_eq("miss_hit", bus.hit, 0);
    check_eq("miss_stall", bus.stall, 1);
    tick();
    check_eq("refill_req", bus.mem_req, 1);
    check_eq("refill_addr", bus.mem_addr, a & 32'hffff_fff0);
    check_eq("refill_stall", bus.stall, 1);
    check_eq("gap_no_we", bus.refill_we, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.mem_valid = 1'b1;
      #1;
      check_eq("beat_we", bus.refill_we, 1);
      check_eq("beat_addr", bus.cache_addr, 32'(base) + 32'(i));
      tick();
    end
    bus.mem_valid = 1'b0;
    #1;
    check_eq("fill_hit", bus.hit, 1);
    check_eq("fill_stall", bus.stall, 0);
    check_eq("fill_way", bus.way_sel, 32'(base[2]));
    check_eq("fill_req_off", bus.mem_req, 0);
    check_eq("fill_caddr", bus.cache_addr, 32'(base) + 32'(a[3:2]));
    tick();
    bus.rd_en = 1'b0;
  endtask

  // Read lookup without letting a miss start a refill.
  task automatic probe(input logic [31:0] a, input logic exp_hit, input logic [4:0] exp_caddr);
    bus.addr = a; bus.rd_en = 1'b1;
    #1;
    check_eq("probe_hit", bus.hit, 32'(exp_hit));
    check_eq("probe_stall", bus.stall, 32'(!exp_hit));
    if (exp_hit) begin
      check_eq("probe_caddr", bus.cache_addr, 32'(exp_caddr));
      check_eq("probe_way", bus.way_sel, 32'(exp_caddr[2]));
    end
    bus.rd_en = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.addr = 32'h40; bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.invalid = 1'b0;
    bus.mem_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check_eq("rst_mem_req", bus.mem_req, 0);
    check_eq("rst_hit", bus.hit, 0);
    check_eq("rst_stall", bus.stall, 0);
    check_eq("rst_data_we", bus.data_we, 0);
    check_eq("rst_refill_we", bus.refill_we, 0);
`ifdef CACHE_STATS_EN
    check_eq("rst_hit_count", bus.hit_count, 0);
    check_eq("rst_miss_count", bus.miss_count, 0);
`endif
    tick();

    // Fill both ways of set 0, then both hit.
    refill(32'h40, 5'd0);
    refill(32'h140, 5'd4);
    probe(32'h40, 1'b1, 5'd0);
    probe(32'h144, 1'b1, 5'd5);

    // Invalidate set0/way1 via 0x144; it must then miss and refill into the free way.
    bus.addr = 32'h144; bus.invalid = 1'b1;
    #1;
    check_eq("inval_hit", bus.hit, 1);
    check_eq("inval_stall", bus.stall, 0);
    tick();
    bus.invalid = 1'b0;
    probe(32'h140, 1'b0, 5'd0);
    refill(32'h140, 5'd4);

    // Set 0 full: round-robin starts at way 0, then way 1, then wraps to way 0.
    refill(32'h240, 5'd0);
    probe(32'h140, 1'b1, 5'd4);
    probe(32'h40, 1'b0, 5'd0);
    refill(32'h40, 5'd4);
    refill(32'h140, 5'd0);

    // Another set: 0x54 -> set 1, way 0, word 1.
    refill(32'h54, 5'd8);

    // Write hit on 0x48 (set0, way1, word2).
    bus.addr = 32'h48; bus.wr_en = 1'b1;
    #1;
    check_eq("wr_hit_we", bus.data_we, 1);
    check_eq("wr_hit_caddr", bus.cache_addr, 32'd6);
    check_eq("wr_hit_stall", bus.stall, 0);
    tick();

    // Write miss with rd_en also high: write wins, no stall, no refill.
    bus.addr = 32'h300; bus.rd_en = 1'b1;
    #1;
    check_eq("wr_miss_we", bus.data_we, 0);
    check_eq("wr_miss_stall", bus.stall, 0);
    tick();
    check_eq("wr_miss_no_req", bus.mem_req, 0);
    bus.rd_en = 1'b0;

    // Write plus invalidate on the same line: write strobes, then the line is gone.
    bus.addr = 32'h48; bus.invalid = 1'b1;
    #1;
    check_eq("wr_inval_we", bus.data_we, 1);
    tick();
    bus.wr_en = 1'b0; bus.invalid = 1'b0;
    probe(32'h40, 1'b0, 5'd0);
    probe(32'h140, 1'b1, 5'd0);

    // Stray mem_valid in IDLE does nothing.
    bus.addr = 32'h0; bus.mem_valid = 1'b1;
    #1;
    check_eq("stray_beat_we", bus.refill_we, 0);
    tick();
    check_eq("stray_beat_req", bus.mem_req, 0);
    bus.mem_valid = 1'b0;

    // Reset in the middle of a refill of 0x240 (victim = free way 1).
    bus.addr = 32'h240; bus.rd_en = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      bus.mem_valid = 1'b1;
      #1;
      check_eq("part_beat_addr", bus.cache_addr, 32'd4 + 32'(i));
      tick();
    end
    bus.rd_en = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check_eq("mid_rst_req", bus.mem_req, 0);
    check_eq("mid_rst_we", bus.refill_we, 0);
    check_eq("mid_rst_stall", bus.stall, 0);
`ifdef CACHE_STATS_EN
    check_eq("mid_rst_hit_count", bus.hit_count, 0);
    check_eq("mid_rst_miss_count", bus.miss_count, 0);
`endif
    tick();
    check_eq("late_beat_we", bus.refill_we, 0);
    bus.mem_valid = 1'b0;
    probe(32'h40, 1'b0, 5'd0);
    probe(32'h140, 1'b0, 5'd0);
    probe(32'h240, 1'b0, 5'd0);
    probe(32'h54, 1'b0, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_control_assoc.md
Name: cache_control_assoc

Overview:
- Parametrised N-way set-associative successor to the direct-mapped cache tag/valid controller.
- Holds tags, valid bits and a per-set round-robin victim pointer.
- Detects hits, drives the external data array address, and runs a multi-beat refill FSM against main memory on read misses.
- Sits between the MIPS core's memory stage and the data RAM / main memory; write-through, no-write-allocate.

Parameters:
- ADDR_WIDTH, 32: byte-address width.
- SETS, 4: number of sets (power of 2, ≥2).
- WAYS, 2: associativity (power of 2, ≥2).
- WORDS_PER_BLOCK, 4: 32-bit words per line (power of 2, ≥2).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- addr  in  ADDR_WIDTH  CPU byte address; held stable by core while stall=1.
- rd_en  in  1  CPU read request.
- wr_en  in  1  CPU write request; has priority over rd_en.
- invalid  in  1  invalidate the line matching addr.
- hit  out  1  tag match in set(addr), combinational.
- stall  out  1  core must hold request.
- way_sel  out  clog2(WAYS)  hit way in IDLE; victim way in REFILL.
- cache_addr  out  clog2(SETS*WAYS*WORDS_PER_BLOCK)  data-array word address {set, way, word}.
- data_we  out  1  write-hit strobe to data array.
- refill_we  out  1  refill-beat strobe to data array (= mem_valid in REFILL).
- mem_req  out  1  refill request, registered.
- mem_addr  out  ADDR_WIDTH  block-aligned refill address (low clog2(WORDS_PER_BLOCK)+2 bits zero).
- mem_valid  in  1  one refill word returned this cycle.

Behaviour:
- Address split: word = addr[clog2(WPB)+1:2]; set = next clog2(SETS) bits; tag = remaining upper bits. addr[1:0] ignored.
- hit = OR over ways of (valid[set][w] && tag[set][w]==tag(addr)). More than one matching way is illegal; the lowest way wins.
- States: IDLE, REFILL.
- IDLE, wr_en=1:
  - hit → data_we=1, cache_addr={set, hit way, word}, stall=0.
  - miss → no action, stall=0.
- IDLE, rd_en=1 (wr_en=0):
  - hit → stall=0, cache_addr={set, hit way, word}.
  - miss → stall=1 (combinational). Latch victim and block address; next state REFILL.
- Victim selection: lowest-index invalid way in the set. If all ways are valid, use rr_ptr[set].
- REFILL:
  - mem_req=1 and stall=1 every cycle.
  - beat_cnt starts at 0. Each mem_valid cycle: refill_we=1, cache_addr={set, victim, beat_cnt}, beat_cnt++.
  - On beat WPB-1: write tag, set valid. If the victim came from rr_ptr, rr_ptr[set] advances by 1 mod WAYS. Next state IDLE.
  - Next cycle: mem_req=0, hit=1, stall=0.
- invalid (IDLE only, evaluated after wr_en in the same cycle): clears valid of the hit way; no effect on miss. Ignored in REFILL.
- rd_en/wr_en/invalid arriving while in REFILL are ignored. The core holds them and they are re-evaluated on return to IDLE.
- mem_valid outside REFILL is ignored.
- Reset (reset=0 at posedge), including mid-refill:
  - state=IDLE, all valid=0, tags=0, rr_ptr=0, beat_cnt=0.
  - Registered outputs: mem_req=0.
  - Combinational outputs with no request: hit=0, stall=0, data_we=0, refill_we=0.
  - Partial refill is discarded.
- Read-miss latency: 1 detect cycle + ≥WPB beat cycles; the data becomes a hit in the cycle after the last beat.

Optional Feature:
- CACHE_STATS_EN defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0].
  - hit_count increments on an IDLE read hit or write hit.
  - miss_count increments once per read miss (on the IDLE detect cycle) and once per write miss.
  - Both counters wrap at 2^32 and clear on reset.
- Not defined: ports and counters absent; no other change.

Test Plan:
- Miss refill: reset, rd 0x40 → hit=0, stall=1; next cycle mem_req=1, mem_addr=0x40. 4 mem_valid beats → refill_we with cache_addr 0,1,2,3. Cycle after: stall=0, hit=1, way_sel=0.
- Second way fill: rd 0x140 → refill into way 1 (cache_addr 4..7). Then rd 0x40 and rd 0x144 both hit with no stall.
- Round-robin eviction: rd 0x240 with set 0 full → victim way 0, rr_ptr→1. Then rd 0x40 misses, rd 0x140 hits; refill of 0x40 evicts way 1.
- Invalidate: invalid with addr 0x144 → set0/way1 valid cleared. Then rd 0x140 → hit=0, stall=1.
- Write path: after filling 0x40, wr 0x48 → data_we=1, cache_addr=2, stall=0. wr 0x300 (miss) → data_we=0, stall=0, mem_req stays 0.
- Reset mid-refill: rd 0x40 miss, 2 beats, then reset=0 for one cycle → mem_req=0 next cycle, later beats ignored. rd 0x40 → hit=0. With CACHE_STATS_EN, counters read 0.
